// File: rtl/fu_mult_pipe.sv
// fu_mult_pipe -- pipelined RISC-V M-extension multiply functional unit.
//
// Purpose:
//   Accepts one multiply op per cycle from issue and returns its 32-bit result
//   NUM_STAGES cycles later on the CDB request/grant handshake. Results retire
//   in accept order. The 64x64 product of the (sign- or zero-extended)
//   operands is built incrementally: each stage-to-stage hop folds in one
//   slice of the multiplier. The last stage picks the low or high word.
//
// Parameters:
//   NUM_STAGES   pipeline depth from accept to result (2..8, default 4)
//
// Ports:
//   clock        rising-edge clock
//   reset        synchronous, active-high reset
//   fu_packet    issued op (valid, inst, func, op1, op2, dest_prn, robn)
//   cdb_gnt      CDB took the result presented this cycle
//   avail        unit can capture fu_packet this cycle
//   result_valid result presented; also the CDB request
//   result_value multiply result
//   result_prn   destination physical register
//   result_robn  ROB index of the op
//
// Configuration macro:
//   MULT_BUBBLE_COLLAPSE_EN  when defined, stages behind empty slots keep
//                            moving during a stall so bubbles get squeezed out.
//                            When undefined, a stall freezes the whole pipe.
//
// Handshake:
//   Issue side: an op is taken when fu_packet.valid & avail at a rising edge.
//   Result side: result_* are held stable while result_valid & ~cdb_gnt; the
//   result retires on the edge where result_valid & cdb_gnt. cdb_gnt without
//   result_valid has no effect.

`ifndef PRN_WIDTH
`define PRN_WIDTH 6
`endif
`ifndef ROB_CNT_WIDTH
`define ROB_CNT_WIDTH 5
`endif

package fu_mult_pkg;
  localparam logic [2:0] FUNC_MUL    = 3'd0;
  localparam logic [2:0] FUNC_MULH   = 3'd1;
  localparam logic [2:0] FUNC_MULHSU = 3'd2;
  localparam logic [2:0] FUNC_MULHU  = 3'd3;

  typedef struct packed {
    logic                      valid;
    logic [31:0]               inst;
    logic [2:0]                func;
    logic [31:0]               op1;
    logic [31:0]               op2;
    logic [`PRN_WIDTH-1:0]     dest_prn;
    logic [`ROB_CNT_WIDTH-1:0] robn;
  } FU_PACKET;
endpackage

module fu_mult_pipe
  import fu_mult_pkg::*;
#(
  parameter int NUM_STAGES = 4
) (
  input  logic                      clock,
  input  logic                      reset,
  input  FU_PACKET                  fu_packet,
  input  logic                      cdb_gnt,
  output logic                      avail,
  output logic                      result_valid,
  output logic [31:0]               result_value,
  output logic [`PRN_WIDTH-1:0]     result_prn,
  output logic [`ROB_CNT_WIDTH-1:0] result_robn
);

  // Multiplier bits consumed per hop; NUM_STAGES-1 hops must cover 64 bits.
  localparam int          CHUNK = (64 + NUM_STAGES - 2) / (NUM_STAGES - 1);
  // For CHUNK=64 the shift yields 0 and the subtraction wraps to all ones.
  localparam logic [63:0] MASK  = (64'd1 << CHUNK) - 64'd1;

  typedef struct packed {
    logic                      valid;
    logic [2:0]                func;
    logic [`PRN_WIDTH-1:0]     prn;
    logic [`ROB_CNT_WIDTH-1:0] robn;
    logic [63:0]               mcand;   // extended op1, pre-shifted per hop
    logic [63:0]               mplier;  // extended op2, remaining slices
    logic [63:0]               sum;     // partial product so far
  } stage_t;

  stage_t                  stage_q [NUM_STAGES];
  stage_t                  stage_d [NUM_STAGES];
  logic [NUM_STAGES-1:0]   free;    // stage may load from upstream this cycle
  logic                    stall;
  logic                    accept;
  logic                    unused_inst;

  assign unused_inst = ^fu_packet.inst;

  // Operand extension: a 64-bit product of extended operands gives the
  // correct high word for every signedness combination.
  function automatic stage_t capture(input FU_PACKET p);
    stage_t r;
    logic   s1;
    logic   s2;
    r        = '0;
    s1       = (p.func == FUNC_MULH) || (p.func == FUNC_MULHSU);
    s2       = (p.func == FUNC_MULH);
    r.valid  = 1'b1;
    r.func   = p.func;
    r.prn    = p.dest_prn;
    r.robn   = p.robn;
    r.mcand  = {{32{s1 & p.op1[31]}}, p.op1};
    r.mplier = {{32{s2 & p.op2[31]}}, p.op2};
    r.sum    = '0;
    return r;
  endfunction

  function automatic stage_t step(input stage_t s);
    stage_t r;
    r        = s;
    r.sum    = s.sum + s.mcand * (s.mplier & MASK);
    r.mcand  = s.mcand << CHUNK;
    r.mplier = s.mplier >> CHUNK;
    return r;
  endfunction

  always_comb begin
    logic chain;
    stall = stage_q[NUM_STAGES-1].valid & ~cdb_gnt;
    chain = ~stall;
    free  = '0;
    free[NUM_STAGES-1] = chain;
    for (int i = NUM_STAGES - 2; i >= 0; i--) begin
`ifdef MULT_BUBBLE_COLLAPSE_EN
      // A stage can load if it is empty or everything downstream can move.
      chain = chain | ~stage_q[i].valid;
`endif
      free[i] = chain;
    end

    accept  = fu_packet.valid & free[0];
    stage_d = stage_q;
    if (free[0]) begin
      if (accept) stage_d[0] = capture(fu_packet);
      else        stage_d[0].valid = 1'b0;
    end
    for (int i = 1; i < NUM_STAGES; i++) begin
      if (free[i]) stage_d[i] = step(stage_q[i-1]);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) stage_q <= '{default: '0};
    else       stage_q <= stage_d;
  end

  assign avail        = free[0];
  assign result_valid = stage_q[NUM_STAGES-1].valid;
  assign result_prn   = stage_q[NUM_STAGES-1].prn;
  assign result_robn  = stage_q[NUM_STAGES-1].robn;

  always_comb begin
    result_value = '0;
    case (stage_q[NUM_STAGES-1].func)
      FUNC_MUL:                           result_value = stage_q[NUM_STAGES-1].sum[31:0];
      FUNC_MULH, FUNC_MULHSU, FUNC_MULHU: result_value = stage_q[NUM_STAGES-1].sum[63:32];
      default:                            result_value = '0;
    endcase
  end

endmodule

// File: tb/tb_fu_mult_pipe.sv
// tb_fu_mult_pipe -- self-checking bench for fu_mult_pipe.
// Reference model: an ordered list of in-flight ops, each with a slot index;
// ops move one slot per cycle toward the output when room allows, and the
// expected value comes from plain 64-bit arithmetic on the operands.
// Honours MULT_BUBBLE_COLLAPSE_EN the same way the design does.

`ifndef PRN_WIDTH
`define PRN_WIDTH 6
`endif
`ifndef ROB_CNT_WIDTH
`define ROB_CNT_WIDTH 5
`endif

module tb_fu_mult_pipe;
  import fu_mult_pkg::*;

  localparam int NS = 4;
  localparam int PW = `PRN_WIDTH;
  localparam int RW = `ROB_CNT_WIDTH;

  logic          clock;
  logic          reset;
  FU_PACKET      fu_packet;
  logic          cdb_gnt;
  logic          avail;
  logic          result_valid;
  logic [31:0]   result_value;
  logic [PW-1:0] result_prn;
  logic [RW-1:0] result_robn;

  fu_mult_pipe #(.NUM_STAGES(NS)) dut (
    .clock        (clock),
    .reset        (reset),
    .fu_packet    (fu_packet),
    .cdb_gnt      (cdb_gnt),
    .avail        (avail),
    .result_valid (result_valid),
    .result_value (result_value),
    .result_prn   (result_prn),
    .result_robn  (result_robn)
  );

  // clock/reset block
  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [31:0]   val;
    logic [PW-1:0] prn;
    logic [RW-1:0] robn;
    int            pos;
  } op_t;

  op_t           q[$];
  int            checks   = 0;
  int            failures = 0;
  logic [31:0]   last_val;
  logic [PW-1:0] last_prn;
  logic [RW-1:0] last_robn;
  int            retired;

  function automatic logic [31:0] ref_mult(input logic [2:0] f, input logic [31:0] a,
                                           input logic [31:0] b);
    longint      sa;
    longint      sb;
    longint      ub;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ub = longint'({32'd0, b});
    case (f)
      3'd0:    begin p = {32'd0, a} * {32'd0, b}; return p[31:0];  end
      3'd1:    begin p = sa * sb;                 return p[63:32]; end
      3'd2:    begin p = sa * ub;                 return p[63:32]; end
      3'd3:    begin p = {32'd0, a} * {32'd0, b}; return p[63:32]; end
      default: return 32'd0;
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs at the falling edge,
  // advance the model, wait for the rising edge.
  task automatic cycle(input logic v, input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [PW-1:0] prn,
                       input logic [RW-1:0] robn, input logic gnt);
    logic rv_e;
    logic stall_e;
    logic avail_e;
    int   prev_np;
    op_t  o;
    op_t  nq[$];
    fu_packet.valid    = v;
    fu_packet.inst     = $urandom;
    fu_packet.func     = f;
    fu_packet.op1      = a;
    fu_packet.op2      = b;
    fu_packet.dest_prn = prn;
    fu_packet.robn     = robn;
    cdb_gnt            = gnt;
    @(negedge clock);
    rv_e    = (q.size() > 0) && (q[0].pos == NS - 1);
    stall_e = rv_e && !gnt;
    prev_np = NS;
    nq      = {};
    foreach (q[i]) begin
      o = q[i];
      if (!(i == 0 && rv_e && gnt)) begin
`ifdef MULT_BUBBLE_COLLAPSE_EN
        o.pos = (o.pos + 1 < prev_np) ? o.pos + 1 : prev_np - 1;
`else
        if (!stall_e) o.pos = o.pos + 1;
`endif
        prev_np = o.pos;
        nq.push_back(o);
      end
    end
`ifdef MULT_BUBBLE_COLLAPSE_EN
    avail_e = (nq.size() == 0) || (nq[nq.size()-1].pos > 0);
`else
    avail_e = !stall_e;
`endif
    chk("result_valid", 64'(result_valid), 64'(rv_e));
    chk("avail", 64'(avail), 64'(avail_e));
    if (rv_e) begin
      chk("result_value", 64'(result_value), 64'(q[0].val));
      chk("result_prn", 64'(result_prn), 64'(q[0].prn));
      chk("result_robn", 64'(result_robn), 64'(q[0].robn));
      if (gnt) begin
        last_val  = result_value;
        last_prn  = result_prn;
        last_robn = result_robn;
        retired++;
      end
    end
    if (v && avail_e) begin
      o.val  = ref_mult(f, a, b);
      o.prn  = prn;
      o.robn = robn;
      o.pos  = 0;
      nq.push_back(o);
    end
    q = nq;
    @(posedge clock);
    #1;
  endtask

  task automatic idle(input int n, input logic gnt);
    for (int i = 0; i < n; i++) cycle(1'b0, 3'd0, 32'd0, 32'd0, '0, '0, gnt);
  endtask

  task automatic rand_op(input logic gnt);
    cycle(1'b1, 3'($urandom_range(0, 3)), $urandom, $urandom,
          PW'($urandom), RW'($urandom), gnt);
  endtask

  // Reset for one edge with a valid packet present; it must not be captured.
  task automatic do_reset();
    reset           = 1'b1;
    fu_packet.valid = 1'b1;
    fu_packet.func  = 3'd0;
    fu_packet.op1   = 32'd3;
    fu_packet.op2   = 32'd9;
    cdb_gnt         = 1'b0;
    @(posedge clock);
    #1;
    reset           = 1'b0;
    fu_packet.valid = 1'b0;
    q.delete();
    @(negedge clock);
    chk("rst_result_valid", 64'(result_valid), 64'd0);
    chk("rst_avail", 64'(avail), 64'd1);
    chk("rst_result_value", 64'(result_value), 64'd0);
    chk("rst_result_prn", 64'(result_prn), 64'd0);
    chk("rst_result_robn", 64'(result_robn), 64'd0);
    @(posedge clock);
    #1;
  endtask

  logic [31:0] corner [6];

  initial begin
    corner = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF, 32'h12345678};
    retired   = 0;
    reset     = 1'b1;
    fu_packet = '0;
    cdb_gnt   = 1'b0;
    @(posedge clock);
    #1;
    do_reset();

    // Basic MUL latency and one-cycle result.
    cycle(1'b1, FUNC_MUL, 32'd7, 32'd6, PW'(5), RW'(3), 1'b1);
    idle(5, 1'b1);
    chk("mul_7x6_value", 64'(last_val), 64'd42);
    chk("mul_7x6_prn", 64'(last_prn), 64'd5);
    chk("mul_7x6_robn", 64'(last_robn), 64'd3);

    // All-ones operands through every func.
    cycle(1'b1, FUNC_MULH, 32'hFFFFFFFF, 32'hFFFFFFFF, PW'(1), RW'(1), 1'b1);
    idle(5, 1'b1);
    chk("mulh_ones", 64'(last_val), 64'h00000000);
    cycle(1'b1, FUNC_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, PW'(2), RW'(2), 1'b1);
    idle(5, 1'b1);
    chk("mulhu_ones", 64'(last_val), 64'hFFFFFFFE);
    cycle(1'b1, FUNC_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, PW'(3), RW'(3), 1'b1);
    idle(5, 1'b1);
    chk("mulhsu_ones", 64'(last_val), 64'hFFFFFFFF);
    cycle(1'b1, FUNC_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, PW'(4), RW'(4), 1'b1);
    idle(5, 1'b1);
    chk("mul_ones", 64'(last_val), 64'h00000001);
    cycle(1'b1, 3'd6, 32'd11, 32'd13, PW'(6), RW'(6), 1'b1);
    idle(5, 1'b1);
    chk("bad_func_zero", 64'(last_val), 64'd0);

    // Four ops back-to-back, held under stall, then drained in order.
    retired = 0;
    for (int i = 0; i < 4; i++) rand_op(1'b0);
    for (int i = 0; i < 4; i++) rand_op(1'b0);
    idle(4, 1'b1);
    chk("drain_count", 64'(retired), 64'd4);

    // Single op stalled at the output while more ops are offered.
    rand_op(1'b0);
    idle(3, 1'b0);
    for (int i = 0; i < 3; i++) rand_op(1'b0);
    idle(8, 1'b1);

    // Full pipeline with grant and new issue in the same cycles.
    for (int i = 0; i < 4; i++) rand_op(1'b1);
    for (int i = 0; i < 5; i++) rand_op(1'b1);
    idle(6, 1'b1);

    // Random traffic with corner operands mixed in.
    for (int i = 0; i < 400; i++) begin
      logic [31:0] a;
      logic [31:0] b;
      a = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      b = ($urandom_range(0, 2) == 0) ? corner[$urandom_range(0, 5)] : $urandom;
      cycle($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), a, b,
            PW'($urandom), RW'($urandom), $urandom_range(0, 2) != 0);
    end
    idle(8, 1'b1);

    // Reset with three ops in flight behind a stalled result.
    for (int i = 0; i < 4; i++) rand_op(1'b0);
    idle(1, 1'b0);
    do_reset();
    idle(10, 1'b1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
